// File: rtl/memory_stage_controller_pkg.sv
// Shared definitions for the memory stage controller.
// Holds the FSM state encoding, the fault cause codes reported on
// fault_cause, and the default number of cycles to wait for dmem_ready.
package memory_stage_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic FAULT_MISALIGNED = 1'b0;
   localparam logic FAULT_TIMEOUT    = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/memory_writeback_pipeline.sv
// MEM/WB pipeline register.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   stall                 hold request from the memory stage; inserts a bubble
//   reg_write             already-gated register write enable of the retiring instruction
//   mem_to_reg, alu_result, rt_rd   fields of the retiring instruction
//   load_data, read_data  capture strobe and data of a completing load
//   wb_*                  registered MEM/WB outputs
module memory_writeback_pipeline (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        reg_write,
   input  logic        mem_to_reg,
   input  logic [31:0] alu_result,
   input  logic [4:0]  rt_rd,
   input  logic        load_data,
   input  logic [31:0] read_data,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [31:0] wb_read_data,
   output logic [31:0] wb_alu_result,
   output logic [4:0]  wb_rt_rd
);

   // NOTE: sequential state is written with <= only, so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_read_data  <= '0;
         wb_alu_result <= '0;
         wb_rt_rd      <= '0;
      end else begin
         if (stall) begin
            // Bubble: nothing retires, the remaining fields keep their value.
            wb_reg_write <= 1'b0;
         end else begin
            wb_reg_write  <= reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_alu_result <= alu_result;
            wb_rt_rd      <= rt_rd;
         end
         if (load_data) begin
            wb_read_data <= read_data;
         end
      end
   end

endmodule

// File: rtl/memory_stage_controller.sv
// Memory stage controller: issues data-memory requests for loads/stores
// held in the EX/MEM register, stalls the pipeline while the memory is not
// ready, reports misaligned and timed-out accesses, and feeds the MEM/WB
// register.
// Ports:
//   clock, reset                         rising-edge clock, sync active-high reset
//   me_*                                 EX/MEM register contents
//   me_stall                             hold request to EX/MEM and upstream
//   dmem_req/we/addr/wdata/ready/rdata   data-memory handshake (word address)
//   wb_*                                 MEM/WB register outputs
//   mem_fault, fault_cause               one-cycle fault pulse and its cause
module memory_stage_controller
   import memory_stage_controller_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        me_mem_read,
   input  logic        me_mem_write,
   input  logic        me_mem_to_reg,
   input  logic        me_reg_write,
   input  logic [31:0] me_alu_result,
   input  logic [31:0] me_data2_reg,
   input  logic [4:0]  me_rt_rd,
   output logic        me_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [29:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [31:0] wb_read_data,
   output logic [31:0] wb_alu_result,
   output logic [4:0]  wb_rt_rd,
   output logic        mem_fault,
   output logic        fault_cause
);

   // The counter only has to reach TIMEOUT_CYCLES-1.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, next_state;
   logic [CNT_W-1:0] wait_cnt, next_cnt;
   logic             next_cause;

   logic             access, aligned, at_limit, kill, load_data;
   logic             req_we_q;
   logic [29:0]      req_addr_q;
   logic [31:0]      req_wdata_q;

   assign access   = me_mem_read | me_mem_write;
   assign aligned  = (me_alu_result[1:0] == 2'b00);
   assign at_limit = (wait_cnt == CNT_LAST);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      next_cnt   = '0;
      next_cause = FAULT_MISALIGNED;
      me_stall   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = me_alu_result[31:2];
      dmem_wdata = me_data2_reg;
      kill       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (access && aligned) begin
               dmem_req = 1'b1;
               dmem_we  = me_mem_write;
               if (!dmem_ready) begin
                  me_stall   = 1'b1;
                  next_state = ST_WAIT;
               end
            end else if (access) begin
               kill       = 1'b1;
               next_state = ST_FAULT;
            end
         end
         ST_WAIT: begin
            // Bus is driven from the captured copy so it cannot move.
            dmem_req   = 1'b1;
            dmem_we    = req_we_q;
            dmem_addr  = req_addr_q;
            dmem_wdata = req_wdata_q;
            if (dmem_ready) begin
               next_state = ST_IDLE;
            end else if (at_limit) begin
               kill       = 1'b1;
               next_cause = FAULT_TIMEOUT;
               next_state = ST_FAULT;
            end else begin
               me_stall   = 1'b1;
               next_cnt   = wait_cnt + CNT_W'(1);
            end
         end
         ST_FAULT: begin
            // No access is started in the fault cycle; a memory instruction
            // sitting here is flushed along with the faulting one.
            kill       = access;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         mem_fault   <= 1'b0;
         fault_cause <= FAULT_MISALIGNED;
      end else begin
         state     <= next_state;
         wait_cnt  <= next_cnt;
         mem_fault <= (next_state == ST_FAULT);
         if (next_state == ST_FAULT) begin
            fault_cause <= next_cause;
         end
      end
   end

   // NOTE: the request capture registers carry no reset: they are only read
   // in WAIT, which is always entered through the cycle that loads them.
   always_ff @(posedge clock) begin
      if (state == ST_IDLE && access && aligned) begin
         req_we_q    <= me_mem_write;
         req_addr_q  <= me_alu_result[31:2];
         req_wdata_q <= me_data2_reg;
      end
   end

   assign load_data = dmem_req & dmem_ready & ~dmem_we & ~me_stall;

   memory_writeback_pipeline u_mem_wb (
      .clock         (clock),
      .reset         (reset),
      .stall         (me_stall),
      .reg_write     (me_reg_write & ~kill),
      .mem_to_reg    (me_mem_to_reg),
      .alu_result    (me_alu_result),
      .rt_rd         (me_rt_rd),
      .load_data     (load_data),
      .read_data     (dmem_rdata),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_read_data  (wb_read_data),
      .wb_alu_result (wb_alu_result),
      .wb_rt_rd      (wb_rt_rd)
   );

endmodule

// File: tb/tb_memory_stage_controller.sv
// Directed bench for memory_stage_controller (TIMEOUT_CYCLES = 4).
module tb_memory_stage_controller;
   import memory_stage_controller_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        me_mem_read, me_mem_write, me_mem_to_reg, me_reg_write;
   logic [31:0] me_alu_result, me_data2_reg;
   logic [4:0]  me_rt_rd;
   logic        me_stall;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [29:0] dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        wb_reg_write, wb_mem_to_reg;
   logic [31:0] wb_read_data, wb_alu_result;
   logic [4:0]  wb_rt_rd;
   logic        mem_fault, fault_cause;

   int checks = 0;
   int errors = 0;
   int writes = 0;

   memory_stage_controller #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset),
      .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
      .me_mem_to_reg(me_mem_to_reg), .me_reg_write(me_reg_write),
      .me_alu_result(me_alu_result), .me_data2_reg(me_data2_reg),
      .me_rt_rd(me_rt_rd), .me_stall(me_stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
      .wb_rt_rd(wb_rt_rd), .mem_fault(mem_fault), .fault_cause(fault_cause)
   );

   always #5 clock = ~clock;

   // Completed write handshakes seen on the bus.
   always @(negedge clock) begin
      if (!reset && dmem_req && dmem_we && dmem_ready) writes++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rt,
                        input logic rdy, input logic [31:0] rdata);
      me_mem_read   = rd;
      me_mem_write  = wr;
      me_mem_to_reg = m2r;
      me_reg_write  = rw;
      me_alu_result = addr;
      me_data2_reg  = data;
      me_rt_rd      = rt;
      dmem_ready    = rdy;
      dmem_rdata    = rdata;
   endtask

   task automatic nop(input logic rdy);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, rdy, 32'h0);
   endtask

   task automatic next_cycle;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      nop(1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      check("rst_wb_rw", wb_reg_write, 0);
      check("rst_wb_rd", wb_read_data, 0);
      check("rst_wb_alu", wb_alu_result, 0);
      check("rst_fault", mem_fault, 0);
      check("rst_cause", fault_cause, 0);
      next_cycle();
      reset = 1'b0;

      // Load at 0x100, ready in the same cycle.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3, 1'b1, 32'hDEADBEEF);
      @(negedge clock);
      check("ld0_stall", me_stall, 0);
      check("ld0_req", dmem_req, 1);
      check("ld0_we", dmem_we, 0);
      check("ld0_addr", dmem_addr, 32'h40);
      next_cycle();
      nop(1'b1);  // stray ready without a request
      @(negedge clock);
      check("ld0_wb_data", wb_read_data, 32'hDEADBEEF);
      check("ld0_wb_rw", wb_reg_write, 1);
      check("ld0_wb_rt", wb_rt_rd, 3);
      check("ld0_wb_m2r", wb_mem_to_reg, 1);
      check("stray_req", dmem_req, 0);
      check("stray_stall", me_stall, 0);
      next_cycle();

      // Store at 0x204, ready after three stall cycles.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h12345678, 5'd0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("st_stall", me_stall, 1);
         check("st_req", dmem_req, 1);
         check("st_we", dmem_we, 1);
         check("st_addr", dmem_addr, 32'h81);
         check("st_wdata", dmem_wdata, 32'h12345678);
         check("st_wb_rw", wb_reg_write, 0);
         next_cycle();
      end
      dmem_ready = 1'b1;
      @(negedge clock);
      check("st_done_stall", me_stall, 0);
      check("st_done_addr", dmem_addr, 32'h81);
      next_cycle();
      nop(1'b0);
      @(negedge clock);
      check("st_after_req", dmem_req, 0);
      check("st_wb_rw_ret", wb_reg_write, 0);
      check("st_writes", writes, 1);
      next_cycle();

      // Misaligned load at 0x102.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd7, 1'b0, 32'h0);
      @(negedge clock);
      check("mis_req", dmem_req, 0);
      check("mis_stall", me_stall, 0);
      next_cycle();
      nop(1'b0);
      @(negedge clock);
      check("mis_fault", mem_fault, 1);
      check("mis_cause", fault_cause, 0);
      check("mis_wb_rw", wb_reg_write, 0);
      check("mis_wb_rt", wb_rt_rd, 7);
      next_cycle();
      @(negedge clock);
      check("mis_fault_end", mem_fault, 0);
      next_cycle();

      // Load at 0x300 that never sees ready: timeout after 4 wait cycles.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd8, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("to_stall", me_stall, 1);
         check("to_req", dmem_req, 1);
         check("to_addr", dmem_addr, 32'hC0);
         next_cycle();
      end
      @(negedge clock);
      check("to_last_stall", me_stall, 0);
      check("to_last_req", dmem_req, 1);
      check("to_last_fault", mem_fault, 0);
      next_cycle();
      nop(1'b0);
      @(negedge clock);
      check("to_fault", mem_fault, 1);
      check("to_cause", fault_cause, 1);
      check("to_req_drop", dmem_req, 0);
      check("to_wb_rw", wb_reg_write, 0);
      check("to_wb_data", wb_read_data, 32'hDEADBEEF);
      next_cycle();
      @(negedge clock);
      check("to_fault_end", mem_fault, 0);
      check("to_req_idle", dmem_req, 0);
      next_cycle();

      // Reset in the second WAIT cycle abandons the access.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd4, 1'b0, 32'h0);
      @(negedge clock);
      check("rw_stall0", me_stall, 1);
      next_cycle();
      @(negedge clock);
      check("rw_stall1", me_stall, 1);
      next_cycle();
      reset = 1'b1;
      @(negedge clock);
      check("rw_in_wait", 32'(dut.state), 32'(ST_WAIT));
      next_cycle();
      reset = 1'b0;
      nop(1'b0);
      @(negedge clock);
      check("rw_state", 32'(dut.state), 32'(ST_IDLE));
      check("rw_req", dmem_req, 0);
      check("rw_wb_rw", wb_reg_write, 0);
      check("rw_wb_data", wb_read_data, 0);
      check("rw_wb_alu", wb_alu_result, 0);
      check("rw_wb_rt", wb_rt_rd, 0);
      check("rw_fault", mem_fault, 0);
      next_cycle();
      @(negedge clock);
      check("rw_fault_later", mem_fault, 0);
      next_cycle();

      // ALU op then a load with one wait cycle, then a back-to-back load.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 5'd5, 1'b0, 32'h0);
      @(negedge clock);
      check("alu_stall", me_stall, 0);
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd9, 1'b0, 32'h0);
      @(negedge clock);
      check("alu_wb_rt", wb_rt_rd, 5);
      check("alu_wb_alu", wb_alu_result, 32'h7);
      check("alu_wb_rw", wb_reg_write, 1);
      check("alu_wb_m2r", wb_mem_to_reg, 0);
      check("ld1_stall", me_stall, 1);
      next_cycle();
      dmem_ready = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      @(negedge clock);
      check("ld1_done_stall", me_stall, 0);
      check("ld1_bubble_rw", wb_reg_write, 0);
      check("ld1_bubble_rt", wb_rt_rd, 5);
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 5'd10, 1'b1, 32'h11111111);
      @(negedge clock);
      check("ld1_wb_rt", wb_rt_rd, 9);
      check("ld1_wb_data", wb_read_data, 32'hCAFEF00D);
      check("ld1_wb_rw", wb_reg_write, 1);
      check("b2b_req", dmem_req, 1);
      check("b2b_addr", dmem_addr, 32'h180);
      check("b2b_stall", me_stall, 0);
      next_cycle();
      nop(1'b0);
      @(negedge clock);
      check("b2b_wb_rt", wb_rt_rd, 10);
      check("b2b_wb_data", wb_read_data, 32'h11111111);
      check("total_writes", writes, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_stage_controller.md
MEMORY_STAGE_CONTROLLER -- requirements
Module: memory_stage_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum wait cycles for dmem_ready before a fault.
REQ-002 SHALL have ports: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have me_mem_read, me_mem_write, me_mem_to_reg, me_reg_write in 1: control bits from the EX/MEM register.
REQ-004 SHALL have me_alu_result in 32 (byte address / ALU value), me_data2_reg in 32 (store data), me_rt_rd in 5 (destination register).
REQ-005 SHALL have me_stall out 1: hold request to the EX/MEM register and upstream stages.
REQ-006 SHALL have dmem_req out 1, dmem_we out 1, dmem_addr out 30 (word address), dmem_wdata out 32, dmem_ready in 1, dmem_rdata in 32.
REQ-007 SHALL have wb_reg_write, wb_mem_to_reg out 1, wb_read_data out 32, wb_alu_result out 32, wb_rt_rd out 5: MEM/WB register.
REQ-008 SHALL have mem_fault out 1 (one-cycle pulse) and fault_cause out 1 (0 = misaligned, 1 = timeout).

Function
REQ-009 SHALL define access = me_mem_read | me_mem_write; aligned = (me_alu_result[1:0] == 0).
REQ-010 SHALL use FSM states IDLE, WAIT, FAULT.
REQ-011 In IDLE with access & aligned: dmem_req = 1 in the same cycle; dmem_we = me_mem_write; dmem_addr = me_alu_result[31:2]; dmem_wdata = me_data2_reg.
REQ-012 If dmem_ready = 1 in that same cycle: complete with zero stall and stay in IDLE; otherwise go to WAIT.
REQ-013 In WAIT: dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay asserted and stable until the dmem_ready cycle; the wait counter increments each cycle.
REQ-014 WAIT with dmem_ready = 1: complete and go to IDLE; the counter clears.
REQ-015 WAIT with counter == TIMEOUT_CYCLES-1 and no ready: go to FAULT, drop dmem_req next cycle, fault_cause = 1.
REQ-016 FAULT lasts exactly one cycle: mem_fault = 1, me_stall = 0, the instruction retires with wb_reg_write = 0; then go to IDLE.
REQ-017 IDLE with access & misaligned: no dmem_req, no stall, mem_fault pulses the next cycle with fault_cause = 0, wb_reg_write = 0 for that instruction.
REQ-018 me_stall SHALL be combinational: 1 iff (IDLE & access & aligned & !dmem_ready) or (WAIT & !dmem_ready & !timeout).
REQ-019 MEM/WB register update when me_stall = 1: wb_reg_write <= 0 (bubble), other wb_* fields hold.
REQ-020 MEM/WB register update when me_stall = 0: load wb_mem_to_reg, wb_alu_result, wb_rt_rd and wb_reg_write from the me_* inputs (wb_reg_write gated per REQ-016/017).
REQ-021 On a completing read (when me_stall = 0), wb_read_data SHALL load dmem_rdata; otherwise it holds its value.
REQ-022 A store SHALL issue exactly one dmem_req handshake; dmem_ready while dmem_req = 0 SHALL be ignored.
REQ-023 Back-to-back accesses SHALL be allowed: a completion in WAIT followed by a new access the next cycle in IDLE, with no idle cycle inserted.
REQ-024 Non-memory instructions SHALL pass to MEM/WB with 1-cycle latency, with no stall.

Reset
REQ-025 While reset = 1 at the clock edge: state = IDLE, counter = 0, all wb_* = 0, mem_fault = 0, fault_cause = 0.
REQ-026 Reset during WAIT SHALL abandon the access; dmem_req = 0 from the next cycle; no fault is reported.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2 bits), the FAULT_MISALIGNED / FAULT_TIMEOUT codes, and the default TIMEOUT_CYCLES.
REQ-028 The MEM/WB register SHALL be a sub-module named memory_writeback_pipeline; the FSM, counter and bus drive stay in the top module.

Verification
REQ-029 Load at addr 0x100, dmem_ready the same cycle with rdata 0xDEADBEEF -> no stall; next cycle wb_read_data = 0xDEADBEEF, wb_reg_write = 1.
REQ-030 Store at 0x204 with data 0x12345678, ready after 3 cycles -> me_stall = 1 for 3 cycles; dmem_addr = 0x81 stable; exactly one write; wb_reg_write = 0 during the stall cycles.
REQ-031 Load at 0x102 -> no dmem_req; next cycle mem_fault = 1, fault_cause = 0, wb_reg_write = 0.
REQ-032 TIMEOUT_CYCLES = 4, load, dmem_ready never asserted -> stall for 4 cycles; then FAULT with mem_fault = 1, fault_cause = 1; dmem_req = 0 afterwards.
REQ-033 Reset asserted in the 2nd WAIT cycle -> next cycle state = IDLE, dmem_req = 0, all wb_* = 0, no mem_fault.
REQ-034 ALU op (rd = 5, result 0x7) followed by a load with 1-cycle ready -> ALU result retires in 1 cycle; load stalls 1 cycle; order is preserved.
